// File: rtl/vend_controller.sv
// Vending machine sequencer: accumulates coin credit, requests a vend at PRICE,
// then pays out change one coin at a time over a req/ack hopper handshake.
module vend_controller #(
    parameter int PRICE    = 100,
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                coin_out_ack,
    output logic                vend_req,
    output logic                coin_out_req,
    output logic [1:0]          coin_out_type,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                busy
);

    typedef enum logic [1:0] {ACCEPT, VEND, CHANGE, GAP} state_t;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] C25     = CREDIT_W'(25);

    state_t                state, state_n;
    logic [CREDIT_W-1:0]   credit_n;
    logic [CREDIT_W:0]     sum, total;
    logic                  vend_req_n, coin_out_req_n, coin_reject_n, busy_n;
    logic [1:0]            coin_out_type_n;

    function automatic logic [1:0] denom(input logic [CREDIT_W-1:0] c);
        if (c >= C25)      return COIN_QUARTER;
        else if (c >= C10) return COIN_DIME;
        else               return COIN_NICKEL;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
        case (t)
            COIN_QUARTER: return C25;
            COIN_DIME:    return C10;
            default:      return C5;
        endcase
    endfunction

    // One extra bit so credit + sum cannot wrap before the PRICE compare.
    always_comb begin
        sum = '0;
        if (valid) begin
            if (nickel)  sum = sum + {1'b0, C5};
            if (dime)    sum = sum + {1'b0, C10};
            if (quarter) sum = sum + {1'b0, C25};
        end
        total = {1'b0, credit} + sum;
    end

    always_comb begin
        state_n       = state;
        credit_n      = credit;
        coin_reject_n = (state != ACCEPT) && (sum != '0);
        case (state)
            ACCEPT: begin
                credit_n = total[CREDIT_W-1:0];
                if (total >= PRICE_X)
                    state_n = VEND;
                else if (cancel && total != '0)
                    state_n = CHANGE;
            end
            VEND: begin
                if (vend_ack) begin
                    credit_n = credit - PRICE_C;
                    state_n  = (credit == PRICE_C) ? ACCEPT : CHANGE;
                end
            end
            CHANGE: begin
                if (coin_out_ack) begin
                    credit_n = credit - coin_value(coin_out_type);
                    state_n  = GAP;
                end
            end
            GAP:     state_n = (credit != '0) ? CHANGE : ACCEPT;
            default: state_n = ACCEPT;
        endcase

        // Outputs are derived from the next state so they register alongside it.
        vend_req_n      = (state_n == VEND);
        coin_out_req_n  = (state_n == CHANGE);
        coin_out_type_n = (state_n == CHANGE) ? denom(credit_n) : COIN_NONE;
        busy_n          = (state_n != ACCEPT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ACCEPT;
            credit        <= '0;
            vend_req      <= 1'b0;
            coin_out_req  <= 1'b0;
            coin_out_type <= COIN_NONE;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            credit        <= credit_n;
            vend_req      <= vend_req_n;
            coin_out_req  <= coin_out_req_n;
            coin_out_type <= coin_out_type_n;
            coin_reject   <= coin_reject_n;
            busy          <= busy_n;
        end
    end

endmodule
